serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator.sv | 114 +++++++++++
 tb/tb_serial_mag_comparator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: compares two WIDTH-bit operands presented MSB first,
// one bit pair per valid cycle, and reports a registered GT/EQ/LT result with a done pulse.
module serial_mag_comparator #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          A,
    input  logic          B,
    output logic          busy,
    output logic          done,
    output logic          GT,
    output logic          EQ,
    output logic          LT,
    output logic [CW-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt_next;
    logic            gt_r;
    logic            lt_r;
    logic            gt_next;
    logic            lt_next;
    logic            res_gt_next;
    logic            res_eq_next;
    logic            res_lt_next;

    // The first differing bit pair (MSB first) decides; later pairs are only counted.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        gt_next     = gt_r;
        lt_next     = lt_r;
        res_gt_next = GT;
        res_eq_next = EQ;
        res_lt_next = LT;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COMPARE;
                    cnt_next   = '0;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                end
            end

            COMPARE: begin
                if (bit_valid) begin
                    cnt_next = cnt + CW'(1);
                    if (!gt_r && !lt_r) begin
                        gt_next = A & ~B;
                        lt_next = ~A & B;
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_next  = DONE;
                        res_gt_next = gt_next;
                        res_lt_next = lt_next;
                        res_eq_next = ~(gt_next | lt_next);
                    end
                end
            end

            DONE: begin
                if (start) begin
                    state_next = COMPARE;
                    cnt_next   = '0;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
            GT    <= 1'b0;
            EQ    <= 1'b1;
            LT    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            gt_r  <= gt_next;
            lt_r  <= lt_next;
            GT    <= res_gt_next;
            EQ    <= res_eq_next;
            LT    <= res_lt_next;
        end
    end

    assign busy = (state == COMPARE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_serial_mag_comparator;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic          bit_valid;
    logic          A;
    logic          B;
    logic          busy;
    logic          done;
    logic          GT;
    logic          EQ;
    logic          LT;
    logic [CW-1:0] cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit checking  = 1'b0;
    logic [2:0] prev_res;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .GT        (GT),
        .EQ        (EQ),
        .LT        (LT),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int required);
        total_cnt++;
        if (actual == required) pass_cnt++;
        else $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    endtask

    // Reference model: collects the operand bits as integers and compares them whole.
    typedef enum int {M_IDLE, M_CMP, M_DONE} m_phase_t;
    m_phase_t m_phase = M_IDLE;
    int       m_cnt   = 0;
    int       m_a     = 0;
    int       m_b     = 0;
    logic     m_gt    = 1'b0;
    logic     m_eq    = 1'b1;
    logic     m_lt    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= M_IDLE;
            m_cnt   <= 0;
            m_a     <= 0;
            m_b     <= 0;
            m_gt    <= 1'b0;
            m_eq    <= 1'b1;
            m_lt    <= 1'b0;
        end else if (m_phase == M_CMP) begin
            if (bit_valid) begin
                m_a   <= m_a * 2 + int'(A);
                m_b   <= m_b * 2 + int'(B);
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == W) begin
                    m_phase <= M_DONE;
                    m_gt    <= (m_a * 2 + int'(A)) >  (m_b * 2 + int'(B));
                    m_eq    <= (m_a * 2 + int'(A)) == (m_b * 2 + int'(B));
                    m_lt    <= (m_a * 2 + int'(A)) <  (m_b * 2 + int'(B));
                end
            end
        end else if (start) begin
            m_phase <= M_CMP;
            m_cnt   <= 0;
            m_a     <= 0;
            m_b     <= 0;
        end else begin
            m_phase <= M_IDLE;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_output("busy", int'(busy), int'(m_phase == M_CMP));
            check_output("done", int'(done), int'(m_phase == M_DONE));
            check_output("cnt", int'(cnt), m_cnt);
            check_output("GT", int'(GT), int'(m_gt));
            check_output("EQ", int'(EQ), int'(m_eq));
            check_output("LT", int'(LT), int'(m_lt));
            check_output("onehot", int'(GT) + int'(EQ) + int'(LT), 1);
        end
    end

    // Runs one comparison starting at the current negedge; ends at the negedge where done is visible.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input int stall_at, input int stall_len, input int start_mid,
                                  input logic [2:0] exp_res, input string tag);
        start     = 1'b1;
        bit_valid = 1'b1;
        A         = 1'b1;
        B         = 1'b0;
        @(negedge clk);
        check_output({tag, "_busy_after_start"}, int'(busy), 1);
        check_output({tag, "_cnt_after_start"}, int'(cnt), 0);
        start = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (W - 1 - i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bit_valid = 1'b0;
                    @(negedge clk);
                    check_output({tag, "_stall_cnt"}, int'(cnt), stall_at);
                    check_output({tag, "_stall_busy"}, int'(busy), 1);
                end
            end
            start     = (W - 1 - i == start_mid);
            bit_valid = 1'b1;
            A         = a[i];
            B         = b[i];
            if (i == 0) begin
                check_output({tag, "_held_res"}, int'({GT, EQ, LT}), int'(prev_res));
                check_output({tag, "_no_early_done"}, int'(done), 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_output({tag, "_done"}, int'(done), 1);
        check_output({tag, "_busy_in_done"}, int'(busy), 0);
        check_output({tag, "_cnt_final"}, int'(cnt), W);
        check_output({tag, "_res"}, int'({GT, EQ, LT}), int'(exp_res));
        prev_res = exp_res;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            bit_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        A         = 1'b0;
        B         = 1'b0;
        prev_res  = 3'b010;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_cnt", int'(cnt), 0);
        check_output("rst_res", int'({GT, EQ, LT}), 3'b010);
        rst = 1'b0;

        apply_stimulus(4'b1010, 4'b1010, -1, 0, -1, 3'b010, "eq");
        idle_cycles(1);
        check_output("eq_done_one_cycle", int'(done), 0);
        apply_stimulus(4'b0110, 4'b0101, -1, 0, 2, 3'b100, "gt_midstart");
        idle_cycles(2);
        apply_stimulus(4'b1000, 4'b1001, -1, 0, -1, 3'b001, "lt_last");
        idle_cycles(1);
        apply_stimulus(4'b1100, 4'b0111, 2, 3, -1, 3'b100, "stall");
        idle_cycles(1);

        // Abort after two accepted bits.
        start     = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b1;
        A         = 1'b0;
        B         = 1'b1;
        repeat (2) @(negedge clk);
        check_output("abort_cnt_before", int'(cnt), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_cnt", int'(cnt), 0);
        check_output("abort_res", int'({GT, EQ, LT}), 3'b010);
        check_output("abort_done", int'(done), 0);
        prev_res = 3'b010;
        idle_cycles(3);
        check_output("abort_no_done", int'(done), 0);

        apply_stimulus(4'b0011, 4'b0010, -1, 0, -1, 3'b100, "b2b_first");
        apply_stimulus(4'b0001, 4'b1000, 1, 1, -1, 3'b001, "b2b_second");
        idle_cycles(2);

        for (int c = 0; c < 1200; c++) begin
            rst       = ($urandom_range(0, 99) < 2);
            start     = ($urandom_range(0, 7) == 0);
            bit_valid = ($urandom_range(0, 3) != 0);
            A         = 1'($urandom_range(0, 1));
            B         = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst = 1'b0;
        idle_cycles(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
